// File: rtl/decimator_seq.sv
// Sequencing controller for the analogue-channel decimator: flush, settle and
// run phases, power-of-two ratio configuration and decimated-output strobe.
module decimator_seq #(
   parameter int RATIO_WIDTH    = 4,
   parameter int FLUSH_CYCLES   = 4,
   parameter int SETTLE_SAMPLES = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   cfg_valid,
   input  logic [RATIO_WIDTH-1:0] cfg_ratio,
   output logic                   cfg_ready,
   input  logic                   in_valid,
   output logic                   dec_rst_n,
   output logic                   dec_ce,
   output logic                   out_valid,
   output logic [RATIO_WIDTH-1:0] ratio,
   output logic                   busy
);

   localparam int PHASE_W  = 2**RATIO_WIDTH - 1;
   localparam int FLUSH_W  = $clog2(FLUSH_CYCLES + 1);
   localparam int SETTLE_W = $clog2(SETTLE_SAMPLES + 1);

   localparam logic [FLUSH_W-1:0]  FLUSH_LAST  = FLUSH_W'(FLUSH_CYCLES - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_SAMPLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      FLUSH,
      SETTLE,
      RUN
   } state_t;

   state_t               state, state_nxt;
   logic [FLUSH_W-1:0]   flush_cnt, flush_cnt_nxt;
   logic [SETTLE_W-1:0]  settle_cnt, settle_cnt_nxt;
   logic [PHASE_W-1:0]   phase, phase_nxt, phase_max;
   logic [PHASE_W:0]     blk_len;
   logic                 cfg_xfer;
   logic                 out_valid_nxt;

   assign cfg_ready = (state == IDLE) || (state == RUN);
   assign busy      = (state == FLUSH) || (state == SETTLE);
   assign dec_ce    = in_valid && ((state == SETTLE) || (state == RUN));
   assign cfg_xfer  = cfg_valid && cfg_ready;

   // Block length is one extra bit wide so ratio = 2^RATIO_WIDTH-1 yields an
   // all-ones phase limit instead of overflowing.
   assign blk_len   = {{PHASE_W{1'b0}}, 1'b1} << ratio;
   assign phase_max = PHASE_W'(blk_len - 1'b1);

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_nxt      = state;
      flush_cnt_nxt  = flush_cnt;
      settle_cnt_nxt = settle_cnt;
      phase_nxt      = phase;
      out_valid_nxt  = 1'b0;

      if (!enable) begin
         state_nxt = IDLE;
      end else if ((state == RUN) && cfg_xfer) begin
         state_nxt     = FLUSH;
         flush_cnt_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt     = FLUSH;
               flush_cnt_nxt = '0;
            end
            FLUSH: begin
               if (flush_cnt == FLUSH_LAST) begin
                  state_nxt      = SETTLE;
                  settle_cnt_nxt = '0;
               end else begin
                  flush_cnt_nxt = flush_cnt + 1'b1;
               end
            end
            SETTLE: begin
               if (in_valid) begin
                  if (settle_cnt == SETTLE_LAST) begin
                     state_nxt = RUN;
                     phase_nxt = '0;
                  end else begin
                     settle_cnt_nxt = settle_cnt + 1'b1;
                  end
               end
            end
            RUN: begin
               if (in_valid) begin
                  if (phase == phase_max) begin
                     phase_nxt     = '0;
                     out_valid_nxt = 1'b1;
                  end else begin
                     phase_nxt = phase + 1'b1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ratio      <= '0;
         dec_rst_n  <= 1'b0;
         out_valid  <= 1'b0;
         flush_cnt  <= '0;
         settle_cnt <= '0;
         phase      <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, independent of statement order.
         state      <= state_nxt;
         flush_cnt  <= flush_cnt_nxt;
         settle_cnt <= settle_cnt_nxt;
         phase      <= phase_nxt;
         out_valid  <= out_valid_nxt;
         dec_rst_n  <= (state_nxt == SETTLE) || (state_nxt == RUN);
         if (cfg_xfer) ratio <= cfg_ratio;
      end
   end

endmodule

// File: tb/tb_decimator_seq.sv
// Directed bench for decimator_seq: reset, ratio configuration, flush/settle
// sequencing, strobe spacing, enable drop and configuration restart.
module tb_decimator_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       cfg_valid;
   logic [3:0] cfg_ratio;
   logic       cfg_ready;
   logic       in_valid;
   logic       dec_rst_n;
   logic       dec_ce;
   logic       out_valid;
   logic [3:0] ratio;
   logic       busy;
   logic [4:0] obs;

   int n_vec = 0;
   int n_err = 0;

   decimator_seq #(
      .RATIO_WIDTH   (4),
      .FLUSH_CYCLES  (4),
      .SETTLE_SAMPLES(16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .cfg_valid (cfg_valid),
      .cfg_ratio (cfg_ratio),
      .cfg_ready (cfg_ready),
      .in_valid  (in_valid),
      .dec_rst_n (dec_rst_n),
      .dec_ce    (dec_ce),
      .out_valid (out_valid),
      .ratio     (ratio),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Observed bundle order: dec_rst_n, dec_ce, busy, cfg_ready, out_valid
   assign obs = {dec_rst_n, dec_ce, busy, cfg_ready, out_valid};

   task automatic clk_step();
      @(posedge clk);
      #1;
   endtask

   // Entered FLUSH on the previous edge; walks FLUSH then n_samp SETTLE samples.
   task automatic flush_settle(input int gap, input logic [3:0] exp_ratio, input int n_samp);
      int   taken;
      int   c;
      logic v;
      taken = 0;
      c     = 0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         #1;
         n_vec++;
         if (obs !== 5'b00100 || ratio !== exp_ratio) begin
            n_err++;
            $display("FAIL flush[%0d]: obs=%b ratio=%0d, want obs=00100 ratio=%0d",
                     i, obs, ratio, exp_ratio);
         end
         clk_step();
      end
      while (taken < n_samp) begin
         v = ((c % gap) == 0);
         in_valid = v;
         #1;
         n_vec++;
         if (obs !== {1'b1, v, 1'b1, 1'b0, 1'b0} || ratio !== exp_ratio) begin
            n_err++;
            $display("FAIL settle[%0d]: obs=%b ratio=%0d, want obs=%b ratio=%0d",
                     c, obs, ratio, {1'b1, v, 3'b100}, exp_ratio);
         end
         if (v) taken++;
         c++;
         clk_step();
      end
      in_valid = 1'b0;
   endtask

   // In RUN with phase 0 (relative); feeds n_samp samples spaced by gap.
   task automatic run_check(input int r, input int gap, input int n_samp, input logic fire0);
      int   taken;
      int   c;
      int   blk;
      logic v;
      logic fire;
      taken = 0;
      c     = 0;
      blk   = 1 << r;
      fire  = fire0;
      while (taken < n_samp) begin
         v = ((c % gap) == 0);
         in_valid = v;
         #1;
         n_vec++;
         if (obs !== {1'b1, v, 1'b0, 1'b1, fire}) begin
            n_err++;
            $display("FAIL run_r%0d[%0d]: obs=%b, want %b", r, c, obs, {1'b1, v, 2'b01, fire});
         end
         if (v) begin
            fire = ((taken % blk) == (blk - 1));
            taken++;
         end else begin
            fire = 1'b0;
         end
         c++;
         clk_step();
      end
      in_valid = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== fire) begin
         n_err++;
         $display("FAIL run_r%0d_tail: out_valid=%b, want %b", r, out_valid, fire);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         enable    = 1'($urandom);
         cfg_valid = 1'($urandom);
         cfg_ratio = 4'($urandom);
         in_valid  = 1'($urandom);
         #1;
         n_vec++;
         if (obs !== 5'b00010 || ratio !== 4'd0) begin
            n_err++;
            $display("FAIL reset_hold[%0d]: obs=%b ratio=%0d, want 00010 0", i, obs, ratio);
         end
         clk_step();
      end
      enable    = 1'b0;
      cfg_valid = 1'b0;
      cfg_ratio = 4'd0;
      in_valid  = 1'b0;
      rst_n     = 1'b1;
      clk_step();
      n_vec++;
      if (obs !== 5'b00010 || ratio !== 4'd0) begin
         n_err++;
         $display("FAIL reset_release: obs=%b ratio=%0d, want 00010 0", obs, ratio);
      end
   endtask

   task automatic test_ratio2();
      cfg_valid = 1'b1;
      cfg_ratio = 4'd2;
      #1;
      n_vec++;
      if (cfg_ready !== 1'b1) begin
         n_err++;
         $display("FAIL idle_cfg_ready: got %b, want 1", cfg_ready);
      end
      clk_step();
      cfg_valid = 1'b0;
      n_vec++;
      if (ratio !== 4'd2 || obs !== 5'b00010) begin
         n_err++;
         $display("FAIL idle_cfg_write: ratio=%0d obs=%b, want 2 00010", ratio, obs);
      end
      enable = 1'b1;
      clk_step();
      flush_settle(1, 4'd2, 16);
      run_check(2, 1, 16, 1'b0);
   endtask

   task automatic test_cfg_in_run();
      run_check(2, 1, 3, 1'b1);
      cfg_valid = 1'b1;
      cfg_ratio = 4'd3;
      in_valid  = 1'b1;
      #1;
      n_vec++;
      if (cfg_ready !== 1'b1) begin
         n_err++;
         $display("FAIL run_cfg_ready: got %b, want 1", cfg_ready);
      end
      clk_step();
      cfg_valid = 1'b0;
      flush_settle(1, 4'd3, 16);
      run_check(3, 1, 24, 1'b0);
   endtask

   task automatic test_cfg_held();
      cfg_valid = 1'b1;
      cfg_ratio = 4'd0;
      clk_step();
      cfg_ratio = 4'd5;
      flush_settle(2, 4'd0, 16);
      cfg_ratio = 4'd0;
      #1;
      n_vec++;
      if (cfg_ready !== 1'b1 || busy !== 1'b0 || ratio !== 4'd0) begin
         n_err++;
         $display("FAIL held_cfg_resume: rdy=%b busy=%b ratio=%0d, want 1 0 0",
                  cfg_ready, busy, ratio);
      end
      clk_step();
      cfg_valid = 1'b0;
      flush_settle(2, 4'd0, 16);
      run_check(0, 2, 8, 1'b0);
   endtask

   task automatic test_drop_settle();
      cfg_valid = 1'b1;
      cfg_ratio = 4'd2;
      clk_step();
      cfg_valid = 1'b0;
      flush_settle(1, 4'd2, 5);
      enable    = 1'b0;
      cfg_valid = 1'b1;
      cfg_ratio = 4'd1;
      in_valid  = 1'b1;
      #1;
      n_vec++;
      if (cfg_ready !== 1'b0) begin
         n_err++;
         $display("FAIL settle_cfg_ready: got %b, want 0", cfg_ready);
      end
      clk_step();
      n_vec++;
      if (obs !== 5'b00010 || ratio !== 4'd2) begin
         n_err++;
         $display("FAIL settle_drop: obs=%b ratio=%0d, want 00010 2", obs, ratio);
      end
      clk_step();
      cfg_valid = 1'b0;
      n_vec++;
      if (ratio !== 4'd1) begin
         n_err++;
         $display("FAIL idle_cfg_after_drop: ratio=%0d, want 1", ratio);
      end
      for (int i = 0; i < 3; i++) begin
         clk_step();
         n_vec++;
         if (obs !== 5'b00010) begin
            n_err++;
            $display("FAIL idle_ignore[%0d]: obs=%b, want 00010", i, obs);
         end
      end
   endtask

   task automatic test_drop_run();
      in_valid  = 1'b0;
      enable    = 1'b1;
      cfg_valid = 1'b1;
      cfg_ratio = 4'd2;
      clk_step();
      cfg_valid = 1'b0;
      flush_settle(1, 4'd2, 16);
      run_check(2, 1, 6, 1'b0);
      enable   = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         clk_step();
         n_vec++;
         if (obs !== 5'b00010) begin
            n_err++;
            $display("FAIL run_drop[%0d]: obs=%b, want 00010", i, obs);
         end
      end
      in_valid = 1'b0;
      enable   = 1'b1;
      clk_step();
      flush_settle(1, 4'd2, 16);
      run_check(2, 1, 8, 1'b0);
   endtask

   task automatic test_reset_mid_run();
      run_check(2, 1, 3, 1'b1);
      in_valid  = 1'b1;
      cfg_valid = 1'b1;
      cfg_ratio = 4'd7;
      rst_n     = 1'b0;
      #1;
      n_vec++;
      if (obs !== 5'b00010 || ratio !== 4'd0) begin
         n_err++;
         $display("FAIL reset_async: obs=%b ratio=%0d, want 00010 0", obs, ratio);
      end
      clk_step();
      n_vec++;
      if (obs !== 5'b00010 || ratio !== 4'd0) begin
         n_err++;
         $display("FAIL reset_async_hold: obs=%b ratio=%0d, want 00010 0", obs, ratio);
      end
      enable    = 1'b0;
      cfg_valid = 1'b0;
      in_valid  = 1'b0;
      rst_n     = 1'b1;
      clk_step();
      n_vec++;
      if (obs !== 5'b00010 || ratio !== 4'd0) begin
         n_err++;
         $display("FAIL reset_async_release: obs=%b ratio=%0d, want 00010 0", obs, ratio);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      enable    = 1'b0;
      cfg_valid = 1'b0;
      cfg_ratio = 4'd0;
      in_valid  = 1'b0;
      test_reset();
      test_ratio2();
      test_cfg_in_run();
      test_cfg_held();
      test_drop_settle();
      test_drop_run();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
